mips_trap_monitor: RTL
======================

Name: mips_trap_monitor

Overview:
- Synthesizable run/trap monitor on the MIPS CPU data-memory request bus, in the PL next to mips_cpu.
- Generalises the single "good trap" check (CPU writes 0 to 0x4000_000C) to NUM_CHAN watched trap words, plus a progress watchdog for deadlock detection.
- Results are readable by the host over the existing MMIO path; the run terminates on trap, abort or watchdog expiry.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory data width
NUM_CHAN, 4, trap channels; channel i watches TRAP_BASE + 4*i
TRAP_BASE, 32'h4000_000C, address of channel 0 trap word
CNT_W, 32, width of cycle and memory-op counters
WDOG_CYCLES, 65536, idle cycles without accepted memory op before TIMEOUT (>= 2)

Ports:
mips_cpu_clk  in  1  clock
mips_cpu_reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin run
abort  in  1  one-cycle pulse: force terminal ABORT
chan_en  in  NUM_CHAN  per-channel enable; sampled at start
mem_addr  in  ADDR_W  CPU request address
mem_wdata  in  DATA_W  CPU write data
mem_write  in  1  CPU write request
mem_read  in  1  CPU read request
mem_req_ready  in  1  memory accepts request this cycle
state  out  3  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 ABORT
done  out  1  high in any terminal state
trap_chan  out  $clog2(NUM_CHAN) (min 1)  channel that ended the run
trap_code  out  DATA_W  value written to the trap word
cycle_cnt  out  CNT_W  cycles spent in RUN
mem_op_cnt  out  CNT_W  accepted memory ops during RUN
irq  out  1  one-cycle pulse on entry to any terminal state

Behaviour:
- Reset: state=IDLE, done=0, irq=0, trap_chan=0, trap_code=0, cycle_cnt=0, mem_op_cnt=0, watchdog=0, latched enables=0.
- Accepted op: (mem_write|mem_read) & mem_req_ready. Trap hit: accepted write, mem_addr == TRAP_BASE+4*i, latched enable i set.
- IDLE/terminal --start--> RUN next cycle; counters, watchdog, trap_chan, trap_code cleared, chan_en latched. start in RUN is ignored.
- RUN: cycle_cnt += 1 per cycle, saturating at all-ones. mem_op_cnt += 1 per accepted op, saturating. Watchdog clears on accepted op, else increments.
- RUN exits, priority highest first: abort -> ABORT; trap hit -> PASS if mem_wdata == 0, else FAIL; watchdog == WDOG_CYCLES-1 with no accepted op -> TIMEOUT.
- Multiple channels hit the same cycle: lowest index wins. The trap cycle's op is counted.
- Terminal states hold all outputs until next start. irq pulses exactly one cycle, registered, the cycle state first shows terminal. abort outside RUN is ignored.
- Latency: trap write accepted in cycle N -> state/done/trap_* valid at cycle N+1.
- Unaligned or disabled-channel writes are ordinary ops; they reset the watchdog.
- Async reset mid-run returns to IDLE immediately, with no irq.

Optional Feature:
- TRAP_LOG_EN defined: adds output trap_pc_addr (ADDR_W), the address of the last accepted op before the terminal transition (the trap address for PASS/FAIL, last progress address for TIMEOUT), reset 0 and cleared on start. Also adds a 2-entry history of the two prior accepted write addresses: hist0_addr, hist1_addr.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package mips_trap_pkg holds:
  - trap_state_e enum with the encodings above;
  - TRAP_STRIDE = 4;
  - the function chan_addr(base,i).
- One sub-module, trap_sat_counter (parametrised width, clear, inc, saturate), instantiated for cycle_cnt, mem_op_cnt and the watchdog.

Test Plan:
- start, 10 reads, then write 0 to 0x4000_000C with ready=1, chan_en=4'b0001 -> PASS, trap_chan=0, trap_code=0, mem_op_cnt=11, irq one cycle.
- Write 32'h5 to 0x4000_0014 with chan_en=4'b0100 -> FAIL, trap_chan=2, trap_code=5.
- Write 0 to 0x4000_0010 with chan_en=4'b0001 -> stays RUN; the write only counts as an op.
- WDOG_CYCLES=16, no ops after start -> TIMEOUT on the 16th RUN cycle, cycle_cnt=16.
- abort and trap hit in the same cycle -> ABORT; a second start afterwards -> RUN with counters cleared.
- mips_cpu_reset_n low during RUN with ready held low (mem_write=1 but not accepted) -> state IDLE, no irq, no op counted.

Source files
------------

// File: rtl/mips_trap_monitor_pkg.sv
// Shared types and helpers for the MIPS run/trap monitor.
package mips_trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4,
    ST_ABORT   = 3'd5
  } trap_state_e;

  localparam int unsigned TRAP_STRIDE = 4;

  // Address of trap word i, channels are packed one word apart from base.
  function automatic logic [31:0] chan_addr(input logic [31:0] base, input int unsigned i);
    return base + 32'(TRAP_STRIDE * i);
  endfunction

endpackage

// File: rtl/trap_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module trap_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  // Clear wins over increment; increment stops at the saturation value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 q <= '0;
    else if (clr)               q <= '0;
    else if (inc && (q != '1))  q <= q + 1'b1;
  end

endmodule

// File: rtl/mips_trap_monitor.sv
// Run/trap monitor on the CPU data-memory request bus. Watches NUM_CHAN trap
// words starting at TRAP_BASE and a progress watchdog; ends the run on trap,
// abort or watchdog expiry and holds the result until the next start.
// Optional macro TRAP_LOG_EN adds trap_pc_addr and a two-entry write history.
module mips_trap_monitor
  import mips_trap_pkg::*;
#(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          NUM_CHAN    = 4,
  parameter logic [31:0] TRAP_BASE   = 32'h4000_000C,
  parameter int          CNT_W       = 32,
  parameter int          WDOG_CYCLES = 65536,
  localparam int         TC_W        = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
  input  logic                mips_cpu_clk,
  input  logic                mips_cpu_reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [NUM_CHAN-1:0] chan_en,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_write,
  input  logic                mem_read,
  input  logic                mem_req_ready,
  output logic [2:0]          state,
  output logic                done,
  output logic [TC_W-1:0]     trap_chan,
  output logic [DATA_W-1:0]   trap_code,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    mem_op_cnt,
  output logic                irq
`ifdef TRAP_LOG_EN
  ,
  output logic [ADDR_W-1:0]   trap_pc_addr,
  output logic [ADDR_W-1:0]   hist0_addr,
  output logic [ADDR_W-1:0]   hist1_addr
`endif
);

  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;

  trap_state_e         st;
  logic [NUM_CHAN-1:0] en_q;
  logic [NUM_CHAN-1:0] hit;
  logic [TC_W-1:0]     hit_idx;
  logic [WD_W-1:0]     wd_q;
  logic                acc, wr_acc, run, go, any_hit, wd_exp;

  assign acc     = (mem_write | mem_read) & mem_req_ready;
  assign wr_acc  = mem_write & mem_req_ready;
  assign run     = (st == ST_RUN);
  assign go      = start & ~run;
  assign any_hit = |hit;
  assign wd_exp  = (wd_q == WD_W'(WDOG_CYCLES - 1)) & ~acc;
  assign state   = st;
  assign done    = (st != ST_IDLE) && (st != ST_RUN);

  for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
    assign hit[i] = wr_acc & en_q[i] & (mem_addr == ADDR_W'(chan_addr(TRAP_BASE, i)));
  end

  // Lowest-index channel wins when several hit together.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--)
      if (hit[i]) hit_idx = TC_W'(i);
  end

  // Run control: start/terminal transitions, result capture, irq on entry to terminal.
  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
    if (!mips_cpu_reset_n) begin
      st        <= ST_IDLE;
      en_q      <= '0;
      trap_chan <= '0;
      trap_code <= '0;
      irq       <= 1'b0;
    end else begin
      irq <= 1'b0;
      if (go) begin
        st        <= ST_RUN;
        en_q      <= chan_en;
        trap_chan <= '0;
        trap_code <= '0;
      end else if (run) begin
        if (abort) begin
          st  <= ST_ABORT;
          irq <= 1'b1;
        end else if (any_hit) begin
          st        <= (mem_wdata == '0) ? ST_PASS : ST_FAIL;
          trap_chan <= hit_idx;
          trap_code <= mem_wdata;
          irq       <= 1'b1;
        end else if (wd_exp) begin
          st  <= ST_TIMEOUT;
          irq <= 1'b1;
        end
      end
    end
  end

  trap_sat_counter #(.W(CNT_W)) u_cycle (
    .clk(mips_cpu_clk), .rst_n(mips_cpu_reset_n),
    .clr(go), .inc(run), .q(cycle_cnt)
  );

  trap_sat_counter #(.W(CNT_W)) u_memop (
    .clk(mips_cpu_clk), .rst_n(mips_cpu_reset_n),
    .clr(go), .inc(run & acc), .q(mem_op_cnt)
  );

  // Watchdog counts idle RUN cycles; any accepted op restarts it.
  trap_sat_counter #(.W(WD_W)) u_wdog (
    .clk(mips_cpu_clk), .rst_n(mips_cpu_reset_n),
    .clr(go | (run & acc)), .inc(run), .q(wd_q)
  );

`ifdef TRAP_LOG_EN
  logic exit_run;
  assign exit_run = run & (abort | any_hit | wd_exp);

  // Last accepted address (including the trap op) and the writes that preceded the exit.
  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset_n) begin
    if (!mips_cpu_reset_n) begin
      trap_pc_addr <= '0;
      hist0_addr   <= '0;
      hist1_addr   <= '0;
    end else if (go) begin
      trap_pc_addr <= '0;
      hist0_addr   <= '0;
      hist1_addr   <= '0;
    end else if (run) begin
      if (acc) trap_pc_addr <= mem_addr;
      if (wr_acc && !exit_run) begin
        hist0_addr <= mem_addr;
        hist1_addr <= hist0_addr;
      end
    end
  end
`endif

endmodule
